// File: rtl/ftf_pkg.sv
// Shared constants and helpers for the iterative Fibonacci FTF encoder.
package ftf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ftf_state_t;

  // Fibonacci number with FNS(1) = FNS(2) = 1; FNS(k<1) = 0.
  function automatic logic [63:0] fns(input int k);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = 64'd1;
    b = 64'd1;
    t = 64'd0;
    if (k < 1) begin
      b = 64'd0;
    end else begin
      for (int n = 3; n <= k; n++) begin
        t = a + b;
        a = b;
        b = t;
      end
    end
    return b;
  endfunction

  // Number of bits needed to hold the values 0..v-1.
  function automatic int clog2(input logic [63:0] v);
    int w;
    w = 0;
    for (int n = 0; n < 63; n++) begin
      if ((64'd1 << n) < v) w = n + 1;
      else w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/ftf_step.sv
// One greedy Fibonacci stage: compares the remainder with the threshold of
// bit idx, emits the code bit and subtracts the bit weight when it is set.
module ftf_step
  import ftf_pkg::*;
#(
  parameter int CODE_W = 25,
  parameter int DIN_W  = 18,
  parameter int IW     = 6
) (
  input  logic [DIN_W-1:0] r,
  input  logic [IW-1:0]    idx,
  output logic             code_bit,
  output logic [DIN_W-1:0] r_next
);

  localparam int AW = clog2(64'(CODE_W));

  logic [DIN_W-1:0] wt_tab [CODE_W];
  logic [DIN_W-1:0] th_tab [CODE_W];
  logic [DIN_W-1:0] wt;
  logic [DIN_W-1:0] th;
  logic [AW-1:0]    sel;

  // Weight is FNS(i+1); even bits use the weight as threshold, odd bits FNS(i+2).
  for (genvar g = 0; g < CODE_W; g++) begin : g_tab
    localparam logic [63:0] W_FULL = fns(g + 1);
    localparam logic [63:0] T_FULL = ((g % 2) == 0) ? fns(g + 1) : fns(g + 2);
    assign wt_tab[g] = W_FULL[DIN_W-1:0];
    assign th_tab[g] = T_FULL[DIN_W-1:0];
  end

  assign sel = idx[AW-1:0];

  // Table lookup for this bit position and one greedy subtraction.
  always_comb begin
    if (int'(idx) < CODE_W) begin
      wt = wt_tab[sel];
      th = th_tab[sel];
    end else begin
      wt = {DIN_W{1'b0}};
      th = {DIN_W{1'b1}};
    end
    code_bit = (r >= th);
    r_next   = code_bit ? (r - wt) : r;
  end

endmodule

// File: rtl/ftf_encoder_iter.sv
// Iterative FTF encoder: resolves BPC codeword bits per RUN cycle through a
// chain of ftf_step stages, with valid/ready handshakes on both sides.
module ftf_encoder_iter
  import ftf_pkg::*;
#(
  parameter int  CODE_W = 25,
  parameter int  BPC    = 5,
  localparam int DIN_W  = clog2(fns(CODE_W + 2))
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DIN_W-1:0]  datain,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] codeout,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int              PW     = clog2(64'(CODE_W)) + 1;
  localparam logic [DIN_W-1:0] MAX   = DIN_W'(fns(CODE_W + 2) - 64'd1);
  localparam logic [PW-1:0]   P_TOP  = PW'(CODE_W - 1);
  localparam logic [PW-1:0]   P_STEP = PW'(BPC);
  localparam logic [1:0]      S_IDLE = IDLE;
  localparam logic [1:0]      S_RUN  = RUN;
  localparam logic [1:0]      S_DONE = DONE;

  logic [1:0]        state;
  logic [DIN_W-1:0]  r;
  logic [PW-1:0]     p;
  logic              err;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] code_next;
  logic              last;

  logic [DIN_W-1:0]  rc       [BPC+1];
  logic [DIN_W-1:0]  step_r   [BPC];
  logic [PW-1:0]     lane_idx [BPC];
  logic [BPC-1:0]    lane_bit;
  logic [BPC-1:0]    lane_act;

  assign rc[0] = r;

  // Lane k handles bit p-k; lanes that would reach bit 0 pass r through.
  for (genvar k = 0; k < BPC; k++) begin : g_lane
    assign lane_idx[k] = p - PW'(k);
    assign lane_act[k] = (p > PW'(k));
    ftf_step #(
      .CODE_W(CODE_W),
      .DIN_W (DIN_W),
      .IW    (PW)
    ) u_step (
      .r       (rc[k]),
      .idx     (lane_idx[k]),
      .code_bit(lane_bit[k]),
      .r_next  (step_r[k])
    );
    assign rc[k+1] = lane_act[k] ? step_r[k] : rc[k];
  end

  // Bit 1 falls inside this cycle's window, so this is the final RUN cycle.
  assign last = (p <= P_STEP);

  // Merge the resolved bits into the codeword; force zero for out-of-range words.
  always_comb begin
    code_next = code;
    for (int i = 1; i < CODE_W; i++) begin
      for (int k = 0; k < BPC; k++) begin
        code_next[i] = (lane_act[k] && (lane_idx[k] == PW'(i))) ? lane_bit[k] : code_next[i];
      end
    end
    code_next[0] = last ? rc[BPC][0] : code[0];
    code_next    = (last && err) ? {CODE_W{1'b0}} : code_next;
  end

  // Handshake FSM plus remainder, bit pointer and codeword registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      r       <= {DIN_W{1'b0}};
      p       <= {PW{1'b0}};
      err     <= 1'b0;
      code    <= {CODE_W{1'b0}};
      out_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            r       <= datain;
            p       <= P_TOP;
            err     <= (datain > MAX);
            code    <= {CODE_W{1'b0}};
            out_err <= 1'b0;
            state   <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          r    <= rc[BPC];
          p    <= p - P_STEP;
          code <= code_next;
          if (last) begin
            out_err <= err;
            state   <= S_DONE;
          end else begin
            state <= S_RUN;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
          else state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign codeout   = code;

endmodule
